piezo_tune_sched: RTL and testbench

//  Scheduler for the piezo tone generator. Arbitrates three alarm requests:
//   too_fast (highest), batt_low, en_steer (lowest).

---
 rtl/piezo_tune_sched.sv | 188 ++++++++++++++++++
 tb/tb_piezo_tune_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_tune_sched.sv
// Piezo alarm scheduler: arbitrates too_fast / batt_low / en_steer and walks the
// selected tune note by note over a start/done handshake with the tone generator.
module piezo_tune_sched #(
  parameter bit          FAST_SIM = 1'b1,
  parameter int unsigned GAP_CYC  = 150_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        too_fast,
  input  logic        batt_low,
  input  logic        en_steer,
  input  logic        tone_done,
  output logic        tone_start,
  output logic        tone_abort,
  output logic [14:0] tone_period,
  output logic [24:0] tone_dur,
  output logic [1:0]  active_tune
);

  localparam int unsigned SHIFT    = FAST_SIM ? 9 : 0;
  localparam logic [27:0] GAP_LOAD = 28'(GAP_CYC >> SHIFT);
  // GAP lasts exactly GAP_LOAD cycles: the counter is loaded one short and expires at 0.
  localparam logic [27:0] GAP_INIT = (GAP_LOAD == 28'd0) ? 28'd0 : GAP_LOAD - 28'd1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_PLAY, S_GAP, S_ABORT} state_e;
  typedef enum logic [1:0] {T_NONE = 2'd0, T_FAST = 2'd1, T_BATT = 2'd2, T_STEER = 2'd3} tune_e;

  // Notes are numbered in STEER order; BATT plays them backwards, FAST uses the first three.
  function automatic logic [2:0] note_at(input tune_e t, input logic [2:0] idx);
    return (t == T_BATT) ? 3'd5 - idx : idx;
  endfunction

  function automatic logic [14:0] note_period(input logic [2:0] n);
    int unsigned p;
    case (n)
      3'd0:       p = 31888;
      3'd1:       p = 23890;
      3'd2, 3'd4: p = 18961;
      default:    p = 15944;
    endcase
    return 15'(p >> SHIFT);
  endfunction

  function automatic logic [24:0] note_dur(input logic [2:0] n);
    int unsigned d;
    case (n)
      3'd0, 3'd1, 3'd2: d = 8388608;
      3'd3:             d = 12582912;
      3'd4:             d = 4194304;
      default:          d = 16777216;
    endcase
    return 25'(d >> SHIFT);
  endfunction

  state_e      state_q, state_d;
  tune_e       tune_q, tune_d, req_tune, load_tune;
  logic [2:0]  idx_q, idx_d, load_idx;
  logic [27:0] gap_q, gap_d;
  logic [14:0] period_q, period_d;
  logic [24:0] dur_q, dur_d;
  logic        own_req, higher_req, last_note, load, go_idle;

  always_comb begin
    req_tune = T_NONE;
    if (too_fast)      req_tune = T_FAST;
    else if (batt_low) req_tune = T_BATT;
    else if (en_steer) req_tune = T_STEER;

    case (tune_q)
      T_FAST:  own_req = too_fast;
      T_BATT:  own_req = batt_low;
      T_STEER: own_req = en_steer;
      default: own_req = 1'b0;
    endcase

    // Smaller non-zero tune code means higher priority.
    higher_req = (req_tune != T_NONE) && (req_tune < tune_q);
    last_note  = (tune_q == T_FAST) ? (idx_q == 3'd2) : (idx_q == 3'd5);
  end

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    tune_d    = tune_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    period_d  = period_q;
    dur_d     = dur_q;
    load      = 1'b0;
    go_idle   = 1'b0;
    load_tune = tune_q;
    load_idx  = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (req_tune != T_NONE) begin
          load      = 1'b1;
          load_tune = req_tune;
        end
      end
      S_START: state_d = S_PLAY;
      S_PLAY: begin
        if (tone_done) begin
          if (higher_req) begin
            load      = 1'b1;
            load_tune = req_tune;
          end else if (!own_req) begin
            go_idle = 1'b1;
          end else if (!last_note) begin
            load     = 1'b1;
            load_idx = idx_q + 3'd1;
          end else if (tune_q == T_FAST) begin
            load = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_INIT;
          end
        end else if (too_fast && tune_q != T_FAST) begin
          state_d = S_ABORT;
        end
      end
      S_GAP: begin
        if (too_fast) begin
          state_d = S_ABORT;
        end else if (higher_req) begin
          load      = 1'b1;
          load_tune = req_tune;
        end else if (!own_req) begin
          go_idle = 1'b1;
        end else if (gap_q == 28'd0) begin
          load = 1'b1;
        end else begin
          gap_d = gap_q - 28'd1;
        end
      end
      S_ABORT: begin
        load      = 1'b1;
        load_tune = T_FAST;
      end
      default: go_idle = 1'b1;
    endcase

    if (load) begin
      state_d  = S_START;
      tune_d   = load_tune;
      idx_d    = load_idx;
      gap_d    = 28'd0;
      period_d = note_period(note_at(load_tune, load_idx));
      dur_d    = note_dur(note_at(load_tune, load_idx));
    end
    if (go_idle) begin
      state_d  = S_IDLE;
      tune_d   = T_NONE;
      idx_d    = 3'd0;
      gap_d    = 28'd0;
      period_d = 15'd0;
      dur_d    = 25'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tune_q   <= T_NONE;
      idx_q    <= 3'd0;
      gap_q    <= 28'd0;
      period_q <= 15'd0;
      dur_q    <= 25'd0;
    end else begin
      state_q  <= state_d;
      tune_q   <= tune_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      period_q <= period_d;
      dur_q    <= dur_d;
    end
  end

  assign tone_start  = (state_q == S_START);
  assign tone_abort  = (state_q == S_ABORT);
  assign tone_period = period_q;
  assign tone_dur    = dur_q;
  assign active_tune = tune_q;

endmodule

// File: tb/tb_piezo_tune_sched.sv
// Directed bench for piezo_tune_sched: vector table for note sequencing plus
// hand-written sequences for gap, pre-emption and reset corner cases.
module tb_piezo_tune_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        too_fast, batt_low, en_steer, tone_done;
  logic        tone_start, tone_abort;
  logic [14:0] tone_period;
  logic [24:0] tone_dur;
  logic [1:0]  active_tune;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  // GAP_CYC chosen so the scaled gap is 20 cycles.
  localparam int GAP = 20;

  piezo_tune_sched #(.FAST_SIM(1'b1), .GAP_CYC(512 * GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .too_fast    (too_fast),
    .batt_low    (batt_low),
    .en_steer    (en_steer),
    .tone_done   (tone_done),
    .tone_start  (tone_start),
    .tone_abort  (tone_abort),
    .tone_period (tone_period),
    .tone_dur    (tone_dur),
    .active_tune (active_tune)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ff, bl, es, dn;
    logic        st, ab;
    logic [14:0] per;
    logic [24:0] dur;
    logic [1:0]  tune;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic st, input logic ab,
                            input logic [14:0] per, input logic [24:0] dur, input logic [1:0] tn);
    check({tag, " tone_start"},  32'(tone_start),  32'(st));
    check({tag, " tone_abort"},  32'(tone_abort),  32'(ab));
    check({tag, " tone_period"}, 32'(tone_period), 32'(per));
    check({tag, " tone_dur"},    32'(tone_dur),    32'(dur));
    check({tag, " active_tune"}, 32'(active_tune), 32'(tn));
  endtask

  task automatic v(input logic ff, input logic bl, input logic es, input logic dn,
                   input logic st, input logic ab, input logic [14:0] per,
                   input logic [24:0] dur, input logic [1:0] tn);
    vec_t r;
    r.ff = ff; r.bl = bl; r.es = es; r.dn = dn;
    r.st = st; r.ab = ab; r.per = per; r.dur = dur; r.tune = tn;
    vecs.push_back(r);
  endtask

  task automatic run_vecs();
    vec_t r;
    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      too_fast = r.ff; batt_low = r.bl; en_steer = r.es; tone_done = r.dn;
      tick();
      check_outs($sformatf("vec%0d", vec_no), r.st, r.ab, r.per, r.dur, r.tune);
      vec_no++;
    end
    vecs.delete();
    tone_done = 1'b0;
  endtask

  // Six done pulses starting from PLAY of the first note; ends in the second GAP cycle.
  task automatic six_notes();
    repeat (6) begin
      tone_done = 1'b1; tick();
      tone_done = 1'b0; tick();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    too_fast = 1'b0; batt_low = 1'b0; en_steer = 1'b0; tone_done = 1'b0;
    repeat (3) tick();
    check_outs("reset", 1'b0, 1'b0, 15'd0, 25'd0, 2'd0);
    rst = 1'b0;
    tick();

    // STEER from IDLE, six notes in order, then into GAP; stray done in IDLE ignored.
    v(0,0,0,1, 0,0,  0,     0, 0);
    v(0,0,1,0, 1,0, 62, 16384, 3);
    v(0,0,1,0, 0,0, 62, 16384, 3);
    v(0,0,1,1, 1,0, 46, 16384, 3);
    v(0,0,1,0, 0,0, 46, 16384, 3);
    v(0,0,1,1, 1,0, 37, 16384, 3);
    v(0,0,1,0, 0,0, 37, 16384, 3);
    v(0,0,1,1, 1,0, 31, 24576, 3);
    v(0,0,1,0, 0,0, 31, 24576, 3);
    v(0,0,1,1, 1,0, 37,  8192, 3);
    v(0,0,1,0, 0,0, 37,  8192, 3);
    v(0,0,1,1, 1,0, 31, 32768, 3);
    v(0,0,1,0, 0,0, 31, 32768, 3);
    v(0,0,1,1, 0,0, 31, 32768, 3);
    run_vecs();

    n = 0;
    while (!tone_start && n < 100) begin
      tick();
      n++;
    end
    check("gap_len", 32'(n), 32'(GAP));
    check_outs("repeat", 1'b1, 1'b0, 15'd62, 25'd16384, 2'd3);

    // too_fast mid C7 of STEER: abort, then FAST loops with no gap.
    v(0,0,1,0, 0,0, 62, 16384, 3);
    v(0,0,1,1, 1,0, 46, 16384, 3);
    v(0,0,1,0, 0,0, 46, 16384, 3);
    v(1,0,1,0, 0,1, 46, 16384, 3);
    v(1,0,1,0, 1,0, 62, 16384, 1);
    v(1,0,1,0, 0,0, 62, 16384, 1);
    v(1,0,1,1, 1,0, 46, 16384, 1);
    v(1,0,1,0, 0,0, 46, 16384, 1);
    v(1,0,1,1, 1,0, 37, 16384, 1);
    v(1,0,1,0, 0,0, 37, 16384, 1);
    v(1,0,1,1, 1,0, 62, 16384, 1);
    v(1,0,1,0, 0,0, 62, 16384, 1);
    // too_fast drops at done -> IDLE even with en_steer high; STEER restarts from IDLE.
    v(0,0,1,1, 0,0,  0,     0, 0);
    v(0,0,1,0, 1,0, 62, 16384, 3);
    v(0,0,1,0, 0,0, 62, 16384, 3);
    // too_fast on the same cycle as tone_done: no abort, FAST G6 next cycle.
    v(1,0,1,1, 1,0, 62, 16384, 1);
    v(1,0,1,0, 0,0, 62, 16384, 1);
    v(0,0,0,1, 0,0,  0,     0, 0);
    // batt_low and en_steer together: BATT wins and plays reversed.
    v(0,1,1,0, 1,0, 31, 32768, 2);
    v(0,1,1,0, 0,0, 31, 32768, 2);
    v(0,1,1,1, 1,0, 37,  8192, 2);
    v(0,1,1,0, 0,0, 37,  8192, 2);
    v(0,0,0,1, 0,0,  0,     0, 0);
    // en_steer dropped mid-E7: note completes, then IDLE with no gap.
    v(0,0,1,0, 1,0, 62, 16384, 3);
    v(0,0,1,0, 0,0, 62, 16384, 3);
    v(0,0,1,1, 1,0, 46, 16384, 3);
    v(0,0,1,0, 0,0, 46, 16384, 3);
    v(0,0,1,1, 1,0, 37, 16384, 3);
    v(0,0,1,0, 0,0, 37, 16384, 3);
    v(0,0,0,0, 0,0, 37, 16384, 3);
    v(0,0,0,0, 0,0, 37, 16384, 3);
    v(0,0,0,1, 0,0,  0,     0, 0);
    v(0,0,0,0, 0,0,  0,     0, 0);
    v(0,0,0,0, 0,0,  0,     0, 0);
    run_vecs();

    // Higher-priority batt_low during a STEER gap starts BATT the next cycle.
    en_steer = 1'b1;
    tick(); tick();
    six_notes();
    check("steer_gap start", 32'(tone_start), 32'd0);
    check("steer_gap tune",  32'(active_tune), 32'd3);
    batt_low = 1'b1;
    tick();
    check_outs("gap_to_batt", 1'b1, 1'b0, 15'd31, 25'd32768, 2'd2);

    // Request dropped during a BATT gap: IDLE immediately.
    en_steer = 1'b0;
    tick();
    six_notes();
    check("batt_gap tune", 32'(active_tune), 32'd2);
    batt_low = 1'b0;
    tick();
    check_outs("gap_drop", 1'b0, 1'b0, 15'd0, 25'd0, 2'd0);

    // too_fast during a STEER gap: abort, then FAST G6.
    en_steer = 1'b1;
    tick(); tick();
    six_notes();
    too_fast = 1'b1;
    tick();
    check_outs("gap_abort", 1'b0, 1'b1, 15'd31, 25'd32768, 2'd3);
    tick();
    check_outs("gap_fast", 1'b1, 1'b0, 15'd62, 25'd16384, 2'd1);

    // Reset mid-PLAY clears outputs at once; STEER restarts at G6 after release.
    too_fast = 1'b0;
    tick();
    check("pre_rst tune", 32'(active_tune), 32'd1);
    rst = 1'b1;
    #1;
    check_outs("rst_mid", 1'b0, 1'b0, 15'd0, 25'd0, 2'd0);
    rst = 1'b0;
    tick();
    check_outs("rst_restart", 1'b1, 1'b0, 15'd62, 25'd16384, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
